instr_group_queue: RTL and testbench

//  Circular FIFO of decoded uop groups between decode and the backend rename (RAT) stage.

---
 rtl/instr_group_queue_if.sv | 49 ++++
 rtl/instr_group_queue.sv | 87 ++++++++
 tb/tb_instr_group_queue.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instr_group_queue_if.sv
// instr_group_queue_if
//   Bundles the enqueue (decode side), dequeue (rename side), flush and
//   occupancy signals of the uop group queue.
//   master : the environment driving the queue (decode + backend)
//   slave  : the queue itself
// Signals
//   flush_in            discard all stored groups
//   enq_valid_in        decode presents a group
//   enq_ready_out       queue can accept a group this cycle
//   enq_uops_in         lane i at [i*UOP_BITS +: UOP_BITS]
//   enq_lane_valid_in   per-lane valid mask
//   deq_valid_out       head group available
//   deq_ready_in        backend accepts the head group
//   deq_uops_out        head group payload
//   deq_lane_valid_out  head lane mask, all zero when empty
//   count_out           number of stored groups
//   full_out/empty_out  occupancy flags
interface instr_group_queue_if #(
  parameter int W        = 4,
  parameter int DEPTH    = 8,
  parameter int UOP_BITS = 128
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  flush_in;
  logic                  enq_valid_in;
  logic                  enq_ready_out;
  logic [W*UOP_BITS-1:0] enq_uops_in;
  logic [W-1:0]          enq_lane_valid_in;
  logic                  deq_valid_out;
  logic                  deq_ready_in;
  logic [W*UOP_BITS-1:0] deq_uops_out;
  logic [W-1:0]          deq_lane_valid_out;
  logic [CNT_W-1:0]      count_out;
  logic                  full_out;
  logic                  empty_out;

  modport master (
    output flush_in, enq_valid_in, enq_uops_in, enq_lane_valid_in, deq_ready_in,
    input  enq_ready_out, deq_valid_out, deq_uops_out, deq_lane_valid_out,
           count_out, full_out, empty_out
  );

  modport slave (
    input  flush_in, enq_valid_in, enq_uops_in, enq_lane_valid_in, deq_ready_in,
    output enq_ready_out, deq_valid_out, deq_uops_out, deq_lane_valid_out,
           count_out, full_out, empty_out
  );
endinterface

// File: rtl/instr_group_queue.sv
// instr_group_queue
//   Circular FIFO of decoded uop groups (W lanes each) sitting between decode
//   and the rename stage. A flush from the backend discards every stored
//   group. Groups become visible at the dequeue port the cycle after they are
//   enqueued; there is no bypass path.
// Ports
//   clk_in   clock, all state updates on the rising edge
//   rst_in   synchronous active-high reset
//   q_if     instr_group_queue_if slave modport (enq/deq/flush/occupancy)
module instr_group_queue #(
  parameter int W        = 4,
  parameter int DEPTH    = 8,
  parameter int UOP_BITS = 128
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  instr_group_queue_if.slave   q_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int UW    = W * UOP_BITS;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [UW-1:0]    r_uops [DEPTH];
  logic [W-1:0]     r_mask [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_enqFire;
  logic w_deqFire;

  // Occupancy comes only from the count register, so full and empty stay
  // distinguishable when head and tail coincide. Ready depends on registered
  // state only, which is why a dequeue from a full queue opens a slot one
  // cycle later rather than in the same cycle.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // An all-zero lane mask still completes the handshake but stores nothing.
  assign w_enqFire = q_if.enq_valid_in & ~w_full & (|q_if.enq_lane_valid_in);
  assign w_deqFire = ~w_empty & q_if.deq_ready_in;

  assign q_if.enq_ready_out      = ~w_full;
  assign q_if.deq_valid_out      = ~w_empty;
  assign q_if.deq_uops_out       = r_uops[r_head];
  assign q_if.deq_lane_valid_out = w_empty ? '0 : r_mask[r_head];
  assign q_if.count_out          = r_count;
  assign q_if.full_out           = w_full;
  assign q_if.empty_out          = w_empty;

  // Pointer and count update. Reset beats flush, flush beats any handshake
  // in the same cycle. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (q_if.flush_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enqFire) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_deqFire) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_enqFire && !w_deqFire) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_enqFire && w_deqFire) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Entry storage needs no reset: an entry is only observed after it has
  // been written, and the lane mask output is forced to zero when empty.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !q_if.flush_in && w_enqFire) begin
      r_uops[r_tail] <= q_if.enq_uops_in;
      r_mask[r_tail] <= q_if.enq_lane_valid_in;
    end
  end
endmodule

// File: tb/tb_instr_group_queue.sv
// tb_instr_group_queue
//   Drives the uop group queue through reset, latency, fill/wrap, full with
//   simultaneous handshakes, flush, empty-mask and random traffic phases,
//   comparing every output each cycle against a queue-based reference model.
module tb_instr_group_queue;
  localparam int W        = 4;
  localparam int DEPTH    = 8;
  localparam int UOP_BITS = 128;
  localparam int UW       = W * UOP_BITS;

  typedef struct {
    logic [UW-1:0] uops;
    logic [W-1:0]  mask;
  } group_t;

  logic clk;
  logic rst;

  instr_group_queue_if #(.W(W), .DEPTH(DEPTH), .UOP_BITS(UOP_BITS)) qIf ();

  instr_group_queue #(.W(W), .DEPTH(DEPTH), .UOP_BITS(UOP_BITS)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .q_if   (qIf)
  );

  // Reference model: the stored groups, oldest first.
  group_t modelQ[$];
  int     checks     = 0;
  int     failures   = 0;
  bit     stateKnown = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [UW-1:0] observed,
                             input logic [UW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every DUT output with what the model says the queue holds.
  task automatic checkAll();
    int sz;
    sz = modelQ.size();
    checkOutput("count", UW'(qIf.count_out), UW'(sz));
    checkOutput("full", UW'(qIf.full_out), UW'(sz == DEPTH));
    checkOutput("empty", UW'(qIf.empty_out), UW'(sz == 0));
    checkOutput("enq_ready", UW'(qIf.enq_ready_out), UW'(sz < DEPTH));
    checkOutput("deq_valid", UW'(qIf.deq_valid_out), UW'(sz > 0));
    if (sz > 0) begin
      checkOutput("deq_mask", UW'(qIf.deq_lane_valid_out), UW'(modelQ[0].mask));
      checkOutput("deq_uops", qIf.deq_uops_out, modelQ[0].uops);
    end else begin
      checkOutput("deq_mask_empty", UW'(qIf.deq_lane_valid_out), '0);
    end
  endtask

  function automatic group_t makeGroup(input int id, input logic [W-1:0] mask);
    group_t g;
    for (int i = 0; i < W; i++) begin
      g.uops[i*UOP_BITS +: UOP_BITS] = {32'(id), 32'(i), $urandom, $urandom};
    end
    g.mask = mask;
    return g;
  endfunction

  // One clock cycle: drive inputs, check outputs of the current state,
  // advance the model by the handshake rules, then take the edge.
  task automatic applyStimulus(input logic r, input logic flush, input logic enqValid,
                               input group_t g, input logic deqReady);
    bit enqF;
    bit deqF;
    rst                    = r;
    qIf.flush_in           = flush;
    qIf.enq_valid_in       = enqValid;
    qIf.enq_uops_in        = g.uops;
    qIf.enq_lane_valid_in  = g.mask;
    qIf.deq_ready_in       = deqReady;
    #1;
    if (stateKnown) checkAll();
    enqF = enqValid && (modelQ.size() < DEPTH) && (g.mask != '0);
    deqF = deqReady && (modelQ.size() > 0);
    if (r || flush) begin
      modelQ.delete();
    end else begin
      if (deqF) void'(modelQ.pop_front());
      if (enqF) modelQ.push_back(g);
    end
    @(posedge clk);
    #1;
    stateKnown = 1;
  endtask

  initial begin
    group_t g;
    group_t idle;
    int     id;
    idle = makeGroup(0, '0);
    rst = 1'b1;
    qIf.flush_in = 1'b0;
    qIf.enq_valid_in = 1'b0;
    qIf.enq_uops_in = '0;
    qIf.enq_lane_valid_in = '0;
    qIf.deq_ready_in = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with enqueue attempted.
    g = makeGroup(99, 4'b1111);
    applyStimulus(1, 0, 1, g, 0);
    applyStimulus(1, 0, 1, g, 0);
    checkOutput("t1_count", UW'(qIf.count_out), '0);
    checkOutput("t1_empty", UW'(qIf.empty_out), UW'(1));
    checkOutput("t1_deq_valid", UW'(qIf.deq_valid_out), '0);
    checkOutput("t1_enq_ready", UW'(qIf.enq_ready_out), UW'(1));

    // Latency: not visible in the enqueue cycle, visible the next.
    g = makeGroup(1, 4'b0111);
    checkOutput("t2_deq_valid_t", UW'(qIf.deq_valid_out), '0);
    applyStimulus(0, 0, 1, g, 0);
    checkOutput("t2_deq_valid_t1", UW'(qIf.deq_valid_out), UW'(1));
    checkOutput("t2_mask", UW'(qIf.deq_lane_valid_out), UW'(4'b0111));
    checkOutput("t2_uops", qIf.deq_uops_out, g.uops);
    applyStimulus(0, 0, 0, idle, 1);

    // Fill then interleave dequeues and enqueues, then drain (pointer wrap).
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, makeGroup(i, 4'b1111), 0);
    checkOutput("t3_full", UW'(qIf.full_out), UW'(1));
    checkOutput("t3_enq_ready", UW'(qIf.enq_ready_out), '0);
    for (int i = 8; i < 16; i++) begin
      applyStimulus(0, 0, 0, idle, 1);
      applyStimulus(0, 0, 1, makeGroup(i, W'(i)), 0);
    end
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, idle, 1);
    checkOutput("t3_drained", UW'(qIf.empty_out), UW'(1));

    // Full queue with enqueue and dequeue both offered.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, makeGroup(20 + i, 4'b1010), 0);
    g = makeGroup(40, 4'b1100);
    applyStimulus(0, 0, 1, g, 1);
    checkOutput("t4_count7", UW'(qIf.count_out), UW'(7));
    applyStimulus(0, 0, 1, g, 0);
    checkOutput("t4_count8", UW'(qIf.count_out), UW'(8));
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, idle, 1);

    // Flush with handshakes in the same cycle.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, makeGroup(50 + i, 4'b0001), 0);
    applyStimulus(0, 1, 1, makeGroup(60, 4'b1111), 1);
    checkOutput("t5_count", UW'(qIf.count_out), '0);
    checkOutput("t5_deq_valid", UW'(qIf.deq_valid_out), '0);
    g = makeGroup(61, 4'b1001);
    applyStimulus(0, 0, 1, g, 0);
    checkOutput("t5_first_after_flush", qIf.deq_uops_out, g.uops);
    applyStimulus(0, 0, 0, idle, 1);

    // Empty-mask group is accepted but not stored.
    checkOutput("t6_ready", UW'(qIf.enq_ready_out), UW'(1));
    applyStimulus(0, 0, 1, makeGroup(70, 4'b0000), 1);
    checkOutput("t6_count", UW'(qIf.count_out), '0);
    checkOutput("t6_deq_valid", UW'(qIf.deq_valid_out), '0);

    // Random traffic.
    id = 100;
    for (int n = 0; n < 100; n++) begin
      logic [W-1:0] m;
      m = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      applyStimulus(0, ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    makeGroup(id, m), ($urandom_range(0, 2) != 0));
      id++;
    end
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 0, idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
